// File: rtl/mips_pkg.sv
// Shared encodings for the RISC_MIPS unified-memory arbiter: phase states,
// requester IDs and the default memory geometry.
package mips_pkg;

    localparam int MIPS_AW = 10;
    localparam int MIPS_DW = 32;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RQ_NONE = 2'd0,
        RQ_LD   = 2'd1,
        RQ_DM   = 2'd2,
        RQ_IF   = 2'd3
    } rq_id_t;

    // Bit positions of each requester in eligibility and grant vectors
    localparam int RQ_BIT_LD = 0;
    localparam int RQ_BIT_DM = 1;
    localparam int RQ_BIT_IF = 2;

endpackage

// File: rtl/mips_prio_sel.sv
// Fixed-priority selector (loader > data > fetch) with a fetch override that
// lets a starved fetch beat the data port for one cycle.
module mips_prio_sel
    import mips_pkg::*;
(
    input  logic [2:0] elig_i,
    input  logic       starve_i,
    output logic [2:0] gnt_o,
    output rq_id_t     id_o
);

    always_comb begin
        gnt_o = '0;
        id_o  = RQ_NONE;
        if (elig_i[RQ_BIT_IF] && starve_i) begin
            gnt_o[RQ_BIT_IF] = 1'b1;
            id_o             = RQ_IF;
        end else if (elig_i[RQ_BIT_LD]) begin
            gnt_o[RQ_BIT_LD] = 1'b1;
            id_o             = RQ_LD;
        end else if (elig_i[RQ_BIT_DM]) begin
            gnt_o[RQ_BIT_DM] = 1'b1;
            id_o             = RQ_DM;
        end else if (elig_i[RQ_BIT_IF]) begin
            gnt_o[RQ_BIT_IF] = 1'b1;
            id_o             = RQ_IF;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter/sequencer for the unified instruction/data memory:
// LOAD/RUN/HALT phase FSM, fetch starvation guard and read-valid steering.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW         = MIPS_AW,
    parameter int DW         = MIPS_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LOAD_MODE,
    input  logic          HALTED,
    input  logic          LD_REQ,
    input  logic          LD_WE,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_WDATA,
    output logic          LD_GNT,
    output logic          LD_RVALID,
    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    output logic          DM_GNT,
    output logic          DM_RVALID,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_RVALID,
    output logic [DW-1:0] RDATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic [1:0]    STATE
);

    localparam int            SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    rq_id_t        pend_q, pend_d;
    rq_id_t        win_id;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [2:0]    elig;
    logic [2:0]    gnt;
    logic          starve;
    logic          rd_now;

    always_comb begin
        elig = '0;
        case (state_q)
            ST_LOAD: elig[RQ_BIT_LD] = LD_REQ;
            ST_RUN: begin
                elig[RQ_BIT_DM] = DM_REQ;
                elig[RQ_BIT_IF] = IF_REQ;
            end
            ST_HALT: elig[RQ_BIT_DM] = DM_REQ;
            default: elig = '0;
        endcase
    end

    assign starve = (state_q == ST_RUN) && (scnt_q == SMAX);

    mips_prio_sel u_prio_sel (
        .elig_i   (elig),
        .starve_i (starve),
        .gnt_o    (gnt),
        .id_o     (win_id)
    );

    assign LD_GNT = gnt[RQ_BIT_LD];
    assign DM_GNT = gnt[RQ_BIT_DM];
    assign IF_GNT = gnt[RQ_BIT_IF];

    always_comb begin
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        case (win_id)
            RQ_LD: begin
                MEM_EN    = 1'b1;
                MEM_WE    = LD_WE;
                MEM_ADDR  = LD_ADDR;
                MEM_WDATA = LD_WDATA;
            end
            RQ_DM: begin
                MEM_EN    = 1'b1;
                MEM_WE    = DM_WE;
                MEM_ADDR  = DM_ADDR;
                MEM_WDATA = DM_WDATA;
            end
            RQ_IF: begin
                MEM_EN    = 1'b1;
                MEM_ADDR  = IF_ADDR;
            end
            default: ;
        endcase
    end

    assign rd_now = MEM_EN && !MEM_WE;
    assign pend_d = rd_now ? win_id : RQ_NONE;

    // A loader read keeps us in LOAD from its grant until its data returns
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (!LOAD_MODE && !(rd_now && win_id == RQ_LD) && pend_q != RQ_LD)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (LOAD_MODE)
                    state_d = ST_LOAD;
                else if (HALTED)
                    state_d = ST_HALT;
            end
            ST_HALT: begin
                if (LOAD_MODE)
                    state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        scnt_d = '0;
        if (state_q == ST_RUN && IF_REQ && !IF_GNT)
            scnt_d = DM_GNT ? scnt_q + 1'b1 : scnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_LOAD;
            pend_q  <= RQ_NONE;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            scnt_q  <= scnt_d;
        end
    end

    assign LD_RVALID = (pend_q == RQ_LD);
    assign DM_RVALID = (pend_q == RQ_DM);
    assign IF_RVALID = (pend_q == RQ_IF);
    assign RDATA     = (pend_q != RQ_NONE) ? MEM_RDATA : '0;
    assign STATE     = state_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed phase scenarios plus randomized traffic,
// compared each cycle against a phase-level reference model.
module tb_mips_mem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    localparam int W_NONE = 0;
    localparam int W_LD   = 1;
    localparam int W_DM   = 2;
    localparam int W_IF   = 3;

    logic          CLK = 1'b0;
    logic          RST_N, LOAD_MODE, HALTED;
    logic          LD_REQ, LD_WE, LD_GNT, LD_RVALID;
    logic [AW-1:0] LD_ADDR;
    logic [DW-1:0] LD_WDATA;
    logic          DM_REQ, DM_WE, DM_GNT, DM_RVALID;
    logic [AW-1:0] DM_ADDR;
    logic [DW-1:0] DM_WDATA;
    logic          IF_REQ, IF_GNT, IF_RVALID;
    logic [AW-1:0] IF_ADDR;
    logic [DW-1:0] RDATA;
    logic          MEM_EN, MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic [1:0]    STATE;

    always #5 CLK = ~CLK;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD_MODE(LOAD_MODE), .HALTED(HALTED),
        .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
        .LD_GNT(LD_GNT), .LD_RVALID(LD_RVALID),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_GNT(DM_GNT), .DM_RVALID(DM_RVALID),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID),
        .RDATA(RDATA), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .STATE(STATE)
    );

    // Synchronous 1024x32 memory the arbiter fronts
    logic [DW-1:0] mem [0:1023];
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
            else        MEM_RDATA     <= mem[MEM_ADDR];
        end
    end

    // Reference model state
    int            phase;
    int            streak;
    int            rv_owner;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] ref_mem [0:1023];
    int            last_gnt;
    int            vectors;
    int            miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task tick();
        int            w;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          rd;
        int            n_owner;
        logic [DW-1:0] n_data;
        @(negedge CLK);
        w = W_NONE;
        if (phase == 0) begin
            if (LD_REQ) w = W_LD;
        end else if (phase == 1) begin
            if (IF_REQ && (streak == SMAX || !DM_REQ)) w = W_IF;
            else if (DM_REQ) w = W_DM;
        end else begin
            if (DM_REQ) w = W_DM;
        end
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (w == W_LD) begin e_we = LD_WE; e_addr = LD_ADDR; e_wd = LD_WDATA; end
        if (w == W_DM) begin e_we = DM_WE; e_addr = DM_ADDR; e_wd = DM_WDATA; end
        if (w == W_IF) e_addr = IF_ADDR;

        chk("ld_gnt",    32'(LD_GNT),    32'(w == W_LD));
        chk("dm_gnt",    32'(DM_GNT),    32'(w == W_DM));
        chk("if_gnt",    32'(IF_GNT),    32'(w == W_IF));
        chk("mem_en",    32'(MEM_EN),    32'(w != W_NONE));
        chk("mem_we",    32'(MEM_WE),    32'(e_we));
        chk("mem_addr",  32'(MEM_ADDR),  32'(e_addr));
        chk("mem_wdata", MEM_WDATA,      e_wd);
        chk("ld_rvalid", 32'(LD_RVALID), 32'(rv_owner == W_LD));
        chk("dm_rvalid", 32'(DM_RVALID), 32'(rv_owner == W_DM));
        chk("if_rvalid", 32'(IF_RVALID), 32'(rv_owner == W_IF));
        if (rv_owner != W_NONE) chk("rdata", RDATA, rv_data);
        chk("state",     32'(STATE),     32'(phase));

        @(posedge CLK);
        rd = (w != W_NONE) && !e_we;
        if (w != W_NONE && e_we) ref_mem[e_addr] = e_wd;
        n_owner = rd ? w : W_NONE;
        n_data  = rd ? ref_mem[e_addr] : '0;
        if (phase == 1) begin
            if (w == W_IF || !IF_REQ) streak = 0;
            else if (w == W_DM) streak++;
        end else begin
            streak = 0;
        end
        case (phase)
            0: if (!LOAD_MODE && !(w == W_LD && rd) && rv_owner != W_LD) phase = 1;
            1: if (LOAD_MODE) phase = 0; else if (HALTED) phase = 2;
            default: if (LOAD_MODE) phase = 0;
        endcase
        rv_owner = n_owner;
        rv_data  = n_data;
        if (!RST_N) begin
            phase = 0; streak = 0; rv_owner = W_NONE;
        end
        last_gnt = w;
        #1;
    endtask

    task ld_op(input logic we, input int addr, input logic [DW-1:0] data);
        LD_REQ = 1'b1; LD_WE = we; LD_ADDR = AW'(addr); LD_WDATA = data;
        last_gnt = W_NONE;
        for (int k = 0; k < 8 && last_gnt != W_LD; k++) tick();
        chk("ld_grant_bound", 32'(last_gnt), 32'(W_LD));
        LD_REQ = 1'b0; LD_WE = 1'b0;
    endtask

    task rand_reqs();
        if (last_gnt == W_LD || !LD_REQ) begin
            LD_REQ = ($urandom_range(0, 2) != 0); LD_WE = 1'($urandom_range(0, 1));
            LD_ADDR = AW'($urandom_range(0, 63)); LD_WDATA = $urandom;
        end
        if (last_gnt == W_DM || !DM_REQ) begin
            DM_REQ = ($urandom_range(0, 2) != 0); DM_WE = 1'($urandom_range(0, 1));
            DM_ADDR = AW'($urandom_range(0, 63)); DM_WDATA = $urandom;
        end
        if (last_gnt == W_IF || !IF_REQ) begin
            IF_REQ = ($urandom_range(0, 2) != 0); IF_ADDR = AW'($urandom_range(0, 63));
        end
        if ($urandom_range(0, 39) == 0) LOAD_MODE = ~LOAD_MODE;
        if ($urandom_range(0, 29) == 0) HALTED = ~HALTED;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        phase = 0; streak = 0; rv_owner = W_NONE; rv_data = '0; last_gnt = W_NONE;
        RST_N = 1'b0; LOAD_MODE = 1'b1; HALTED = 1'b0;
        LD_REQ = 1'b0; LD_WE = 1'b0; LD_ADDR = '0; LD_WDATA = '0;
        DM_REQ = 1'b0; DM_WE = 1'b0; DM_ADDR = '0; DM_WDATA = '0;
        IF_REQ = 1'b0; IF_ADDR = '0;

        // Reset values
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_rdata", RDATA, 32'h0);
        tick();
        RST_N = 1'b1;

        // LOAD: loader only, DM/IF requests ignored
        DM_REQ = 1'b1; DM_ADDR = AW'(7); IF_REQ = 1'b1; IF_ADDR = AW'(3);
        ld_op(1'b1, 0, 32'h2820_0005);
        ld_op(1'b0, 0, '0);
        tick();
        for (int a = 1; a < 64; a++)
            ld_op(1'b1, a, (a == 30) ? 32'd15 : $urandom);

        // LOAD -> RUN with a loader read in flight, then first fetch
        DM_REQ = 1'b0; IF_REQ = 1'b0;
        LOAD_MODE = 1'b0;
        LD_REQ = 1'b1; LD_WE = 1'b0; LD_ADDR = AW'(5);
        tick();
        LD_REQ = 1'b0;
        tick();
        IF_REQ = 1'b1; IF_ADDR = AW'(0);
        tick();
        tick();
        IF_REQ = 1'b0;
        tick();

        // Priority: DM before IF
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = AW'(30);
        IF_REQ = 1'b1; IF_ADDR = AW'(4);
        tick();
        DM_REQ = 1'b0;
        tick();
        IF_REQ = 1'b0;
        tick();

        // Starvation guard: DM and IF both continuously requesting
        DM_REQ = 1'b1; DM_WE = 1'b0; IF_REQ = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (last_gnt == W_DM) DM_ADDR = AW'($urandom_range(0, 63));
            if (last_gnt == W_IF) IF_ADDR = AW'($urandom_range(0, 63));
        end
        DM_REQ = 1'b0; IF_REQ = 1'b0;
        tick();

        // HALT: fetch gated, data port still served
        HALTED = 1'b1;
        tick();
        IF_REQ = 1'b1; IF_ADDR = AW'(36);
        tick();
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = AW'(30);
        tick();
        DM_REQ = 1'b0;
        tick();
        HALTED = 1'b0;
        tick();
        tick();
        LOAD_MODE = 1'b1;
        tick();
        IF_REQ = 1'b0; LOAD_MODE = 1'b0;
        tick();
        tick();

        // Randomized traffic across all phases
        for (int k = 0; k < 400; k++) begin
            rand_reqs();
            tick();
        end

        // Return to RUN, then reset while a DM read is pending
        LD_REQ = 1'b0; DM_REQ = 1'b0; IF_REQ = 1'b0; HALTED = 1'b0;
        LOAD_MODE = 1'b1;
        tick();
        tick();
        LOAD_MODE = 1'b0;
        tick();
        tick();
        tick();
        DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = AW'(30);
        RST_N = 1'b0;
        tick();
        DM_REQ = 1'b0;
        chk("rst_mid_rdata", RDATA, 32'h0);
        tick();
        RST_N = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port arbiter and sequencer for the RISC_MIPS unified 1024x32 instruction/data memory. It shares one synchronous memory port among three requesters: the program loader (testbench/debug), the MEM-stage data port (LW/SW) and the IF-stage fetch port. It also sequences the memory through load, run and halt phases, so that program load, execution and post-HLT data inspection never collide.

## Interface
- AW, 10, word-address width (1024 words)
- DW, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; minimum 1

- CLK  in  1  single system clock, rising edge
- RST_N  in  1  synchronous, active-low reset
- LOAD_MODE  in  1  1 = loader owns memory
- HALTED  in  1  CPU has retired HLT; level signal
- LD_REQ, LD_WE  in  1 each  loader request, write enable
- LD_ADDR  in  AW; LD_WDATA  in  DW
- LD_GNT, LD_RVALID  out  1 each
- DM_REQ, DM_WE  in  1 each  data-port request, write enable (SW)
- DM_ADDR  in  AW; DM_WDATA  in  DW
- DM_GNT, DM_RVALID  out  1 each
- IF_REQ  in  1; IF_ADDR  in  AW  fetch is read-only
- IF_GNT, IF_RVALID  out  1 each
- RDATA  out  DW  shared read data, qualified by the *_RVALID signals
- MEM_EN, MEM_WE  out  1 each; MEM_ADDR  out  AW; MEM_WDATA  out  DW
- MEM_RDATA  in  DW  memory read data; 1-cycle synchronous read latency
- STATE  out  2  current phase: 0 LOAD, 1 RUN, 2 HALT

## Operation
- FSM states: LOAD, RUN, HALT. Reset state is LOAD.
- LOAD: only the loader is eligible. Exits to RUN when LOAD_MODE=0 and no loader read is outstanding.
- RUN: eligibility is DM, then IF. Loader requests are ignored. Goes to HALT when HALTED=1 and to LOAD when LOAD_MODE=1. If both are set, LOAD wins.
- HALT: only DM is eligible; fetch is gated. Goes to LOAD when LOAD_MODE=1. HALTED falling alone does not leave HALT.
- Handshake: a requester holds REQ, ADDR, WE and WDATA stable until it sees GNT=1. GNT is combinational in the same cycle. Exactly one GNT is high per cycle, and only if its REQ is high and the requester is eligible.
- The winner drives the MEM_* signals combinationally: MEM_EN=1, MEM_WE=winner WE (always 0 for IF). With no winner, MEM_EN=0 and MEM_WE=0.
- Starvation guard (RUN only), counter SCNT of width clog2(STARVE_MAX+1):
  - SCNT increments on each DM grant while IF_REQ=1.
  - SCNT clears on an IF grant or when IF_REQ=0.
  - When SCNT==STARVE_MAX, IF beats DM in that cycle.
- FSM transitions take effect from the next cycle. Grant in the current cycle uses the current state.

## Timing
- Write: memory is updated at the edge that closes the grant cycle. Zero wait states.
- Read: granted in cycle t. *_RVALID=1 for exactly cycle t+1 with RDATA=MEM_RDATA. RDATA is don't-care when no RVALID is high.
- Back-to-back grants are allowed every cycle, with sustained throughput of 1 access/cycle. Read-after-write to the same address in consecutive cycles returns the new data (memory behaviour).
- A read granted in the last cycle of a state still returns its RVALID in the next state.
- Reset values: all GNT=0, all RVALID=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, RDATA=0, SCNT=0, STATE=0 (LOAD).
- Reset mid-read: the pending RVALID is dropped. No RVALID appears in the first cycle after RST_N rises.
- Address width is exactly AW. There is no wrap or range check.

## Structure
- Shared package mips_pkg holds:
  - state encoding constants ST_LOAD=2'd0, ST_RUN=2'd1, ST_HALT=2'd2
  - requester ID constants RQ_NONE, RQ_LD, RQ_DM, RQ_IF
  - default AW/DW values
- Sub-module mips_prio_sel (combinational):
  - inputs: eligible-request vector and the starvation-override bit
  - outputs: one-hot grant and requester ID
- The top level holds the FSM, SCNT and the pending-read ID register that steers RVALID.

## Test plan
- Load phase: LOAD_MODE=1, loader writes 32'h2820_0005 to address 0, then reads it; DM_REQ and IF_REQ held high throughout → LD_RVALID one cycle after the read grant with RDATA=32'h2820_0005; DM_GNT and IF_GNT stay 0.
- Priority: in RUN, DM_REQ and IF_REQ rise in the same cycle with DM reading address 30 (holding 15) → DM_GNT first; DM_RVALID next cycle with RDATA=15; IF granted in the following cycle.
- Starvation: STARVE_MAX=4, DM_REQ and IF_REQ both held high → grant pattern is DM, DM, DM, DM, IF repeating; SCNT returns to 0 after each IF grant.
- Halt: HALTED=1 in RUN → STATE=2 next cycle; IF_REQ to address 36 is never granted; a DM read of address 30 still returns 15.
- Reset mid-read: DM read granted, RST_N=0 on the following edge → no DM_RVALID; all outputs at reset values; STATE=0.
- Transition: LOAD_MODE 1→0 while a loader read is pending → LD_RVALID delivered first; STATE=1 only after it; IF at address 0 granted in the next cycle.
